// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-master memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   function automatic int lat_cnt_w(input int mem_lat);
      return $clog2(mem_lat + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way combinational arbiter: round-robin on ties, or fixed M0 priority.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       rr_en,
   output logic       gnt_idx,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      gnt_idx = M0;
      if (req == 2'b11) begin
         gnt_idx = rr_en ? ~last_grant : M0;
      end else if (req[1]) begin
         gnt_idx = M1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core (M0) and the loader (M1),
// one transaction at a time, with every output driven from a flop.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1,
   parameter int RR_EN   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LAT_W = lat_cnt_w(MEM_LAT);

   arb_state_t        state, state_d;
   logic              last_grant, last_grant_d;
   logic              gnt_q, gnt_d;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
   logic              mem_en_d, mem_we_d;
   logic [ADDR_W-3:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic [1:0]        ack_d;
   logic              err_d;
   logic [DATA_W-1:0] rdata_d;
   logic              busy_d;

   logic              gnt_idx, any_req;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .rr_en      (RR_EN != 0),
      .gnt_idx    (gnt_idx),
      .any_req    (any_req)
   );

   always_comb begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      if (gnt_idx == M1) begin
         sel_we    = m1_we;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
      end
   end

   // The mem_we/addr/wdata flops double as the transaction latch, so a
   // finished read is recognised by mem_we still being low.
   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      gnt_d        = gnt_q;
      lat_cnt_d    = lat_cnt;
      mem_en_d     = 1'b0;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      ack_d        = '0;
      err_d        = 1'b0;
      rdata_d      = '0;
      case (state)
         IDLE: begin
            if (any_req) begin
               gnt_d        = gnt_idx;
               last_grant_d = gnt_idx;
               mem_we_d     = sel_we;
               mem_addr_d   = sel_addr[ADDR_W-1:2];
               mem_wdata_d  = sel_wdata;
               if (sel_addr[1:0] != 2'b00) begin
                  state_d        = RESP;
                  ack_d[gnt_idx] = 1'b1;
                  err_d          = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  mem_en_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            lat_cnt_d = LAT_W'(MEM_LAT - 1);
            state_d   = WAIT;
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_d      = RESP;
               ack_d[gnt_q] = 1'b1;
               rdata_d      = mem_we ? '0 : mem_rdata;
            end else begin
               lat_cnt_d = lat_cnt - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= M1;
         gnt_q      <= M0;
         lat_cnt    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         last_grant <= last_grant_d;
         gnt_q      <= gnt_d;
         lat_cnt    <= lat_cnt_d;
         mem_en     <= mem_en_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         m0_ack     <= ack_d[0];
         m1_ack     <= ack_d[1];
         m0_err     <= ack_d[0] & err_d;
         m1_err     <= ack_d[1] & err_d;
         m0_rdata   <= ack_d[0] ? rdata_d : '0;
         m1_rdata   <= ack_d[1] ? rdata_d : '0;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (LAT1/RR, LAT1/fixed, LAT3/RR) with a
// pipelined memory model and an ack scoreboard.
module tb_mem_port_arbiter;

   localparam int N = 3;

   typedef struct packed {
      logic        mst;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m0_req [N], m0_we [N], m0_ack [N], m0_err [N];
   logic        m1_req [N], m1_we [N], m1_ack [N], m1_err [N];
   logic [31:0] m0_addr [N], m0_wdata [N], m0_rdata [N];
   logic [31:0] m1_addr [N], m1_wdata [N], m1_rdata [N];
   logic        mem_en [N], mem_we [N], busy [N];
   logic [29:0] mem_addr [N];
   logic [31:0] mem_wdata [N], mem_rdata [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_port_arbiter #(
         .DATA_W  (32),
         .ADDR_W  (32),
         .MEM_LAT ((g == 2) ? 3 : 1),
         .RR_EN   ((g == 1) ? 0 : 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .m0_req    (m0_req[g]),
         .m0_we     (m0_we[g]),
         .m0_addr   (m0_addr[g]),
         .m0_wdata  (m0_wdata[g]),
         .m0_rdata  (m0_rdata[g]),
         .m0_ack    (m0_ack[g]),
         .m0_err    (m0_err[g]),
         .m1_req    (m1_req[g]),
         .m1_we     (m1_we[g]),
         .m1_addr   (m1_addr[g]),
         .m1_wdata  (m1_wdata[g]),
         .m1_rdata  (m1_rdata[g]),
         .m1_ack    (m1_ack[g]),
         .m1_err    (m1_err[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g]),
         .busy      (busy[g])
      );
   end

   // Memory model: word w initially holds 0xCAFE0000|w; data emerges MEM_LAT cycles after mem_en.
   logic [31:0] mem  [N][64];
   logic [31:0] pipe [N][3];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (mem_en[i]) begin
            pipe[i][0] <= mem[i][mem_addr[i][5:0]];
            if (mem_we[i]) mem[i][mem_addr[i][5:0]] <= mem_wdata[i];
         end
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   always_comb begin
      mem_rdata[0] = pipe[0][0];
      mem_rdata[1] = pipe[1][0];
      mem_rdata[2] = pipe[2][2];
   end

   int   checks = 0;
   int   errors = 0;
   int   ack_cnt  [N] = '{default: 0};
   int   men_cnt  [N] = '{default: 0};
   int   menw_cnt [N] = '{default: 0};
   exp_t sbq [N][$];
   exp_t mon_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (mem_en[i] === 1'b1) begin
            men_cnt[i]++;
            if (mem_we[i] === 1'b1) menw_cnt[i]++;
         end
         if (m0_ack[i] === 1'b1 || m1_ack[i] === 1'b1) begin
            ack_cnt[i]++;
            chk($sformatf("sb_expected_ack_i%0d", i), (sbq[i].size() != 0), 1);
            if (sbq[i].size() != 0) begin
               mon_e = sbq[i].pop_front();
               chk($sformatf("sb_winner_i%0d", i), {m1_ack[i], m0_ack[i]},
                   mon_e.mst ? 2'b10 : 2'b01);
               chk($sformatf("sb_rdata_i%0d", i),
                   mon_e.mst ? m1_rdata[i] : m0_rdata[i], mon_e.rd);
               chk($sformatf("sb_err_i%0d", i),
                   mon_e.mst ? m1_err[i] : m0_err[i], mon_e.err);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_req(input int i, input bit mst, input bit we,
                          input logic [31:0] a, input logic [31:0] wd);
      if (mst) begin
         m1_req[i] = 1'b1; m1_we[i] = we; m1_addr[i] = a; m1_wdata[i] = wd;
      end else begin
         m0_req[i] = 1'b1; m0_we[i] = we; m0_addr[i] = a; m0_wdata[i] = wd;
      end
   endtask

   task automatic clr_req(input int i, input bit mst);
      if (mst) m1_req[i] = 1'b0;
      else     m0_req[i] = 1'b0;
   endtask

   task automatic push(input int i, input bit mst, input logic [31:0] rd, input bit err);
      exp_t e;
      e.mst = mst;
      e.rd  = rd;
      e.err = err;
      sbq[i].push_back(e);
   endtask

   task automatic wait_acks(input int i, input int target, input string tag);
      int n;
      n = 0;
      while (ack_cnt[i] < target && n < 40) begin
         step(1);
         n++;
      end
      chk(tag, ack_cnt[i], target);
   endtask

   task automatic txn(input int i, input bit mst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input bit err,
                      input string tag);
      push(i, mst, rd, err);
      set_req(i, mst, we, a, wd);
      wait_acks(i, ack_cnt[i] + 1, tag);
      clr_req(i, mst);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         m0_req[i] = 1'b0;
         m1_req[i] = 1'b0;
      end
      step(2);
      rst = 1'b1;
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0, t1, n;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         m0_req[i] = 1'b0; m0_we[i] = 1'b0; m0_addr[i] = '0; m0_wdata[i] = '0;
         m1_req[i] = 1'b0; m1_we[i] = 1'b0; m1_addr[i] = '0; m1_wdata[i] = '0;
         for (int w = 0; w < 64; w++) mem[i][w] <= 32'hCAFE_0000 | w;
      end
      step(2);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_ctl_i%0d", i),
             {busy[i], mem_en[i], m0_ack[i], m1_ack[i], m0_err[i], m1_err[i]}, 0);
         chk($sformatf("rst_rdata_i%0d", i), m0_rdata[i] | m1_rdata[i], 0);
         chk($sformatf("rst_mem_addr_i%0d", i), mem_addr[i], 0);
      end
      rst = 1'b1;
      step(2);

      // 1: single read, cycle-exact timing on the LAT1 build
      push(0, 1'b0, 32'hCAFE_0004, 1'b0);
      set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
      step(1);
      chk("t1_issue_en", mem_en[0], 1);
      chk("t1_issue_addr", mem_addr[0], 32'h4);
      chk("t1_issue_we", mem_we[0], 0);
      chk("t1_ack_early", m0_ack[0], 0);
      step(1);
      chk("t1_wait_en", mem_en[0], 0);
      chk("t1_ack_early2", m0_ack[0], 0);
      step(1);
      chk("t1_ack", m0_ack[0], 1);
      chk("t1_rdata", m0_rdata[0], 32'hCAFE_0004);
      clr_req(0, 1'b0);
      step(1);

      // 2: both masters held high, round-robin vs fixed priority
      do_reset();
      push(0, 1'b0, 32'hCAFE_0010, 1'b0); push(0, 1'b1, 32'hCAFE_0011, 1'b0);
      push(0, 1'b0, 32'hCAFE_0010, 1'b0); push(0, 1'b1, 32'hCAFE_0011, 1'b0);
      for (int k = 0; k < 3; k++) push(1, 1'b0, 32'hCAFE_0010, 1'b0);
      for (int i = 0; i < 2; i++) begin
         set_req(i, 1'b0, 1'b0, 32'h40, 32'h0);
         set_req(i, 1'b1, 1'b0, 32'h44, 32'h0);
      end
      t0 = ack_cnt[0] + 4;
      t1 = ack_cnt[1] + 3;
      n = 0;
      while ((ack_cnt[0] < t0 || ack_cnt[1] < t1) && n < 60) begin
         step(1);
         n++;
         if (ack_cnt[0] >= t0) begin clr_req(0, 1'b0); clr_req(0, 1'b1); end
         if (ack_cnt[1] >= t1) begin clr_req(1, 1'b0); clr_req(1, 1'b1); end
      end
      step(3);
      chk("t2_rr_acks", ack_cnt[0], t0);
      chk("t2_fixed_acks", ack_cnt[1], t1);
      chk("t2_sb_drained", sbq[0].size() + sbq[1].size(), 0);

      // 3: M1 write then M0 readback
      base = men_cnt[0];
      n = menw_cnt[0];
      txn(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, "t3_wr_ack");
      chk("t3_wr_mem_en", men_cnt[0] - base, 1);
      chk("t3_wr_mem_we", menw_cnt[0] - n, 1);
      txn(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, "t3_rd_ack");

      // 4: misaligned M0 access after an M1 grant; tie then goes to M1
      txn(0, 1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFE_0011, 1'b0, "t4_m1_rd");
      step(1);
      base = men_cnt[0];
      push(0, 1'b0, 32'h0, 1'b1);
      set_req(0, 1'b0, 1'b0, 32'h13, 32'h0);
      step(1);
      chk("t4_err_ack", m0_ack[0], 1);
      chk("t4_err_flag", m0_err[0], 1);
      clr_req(0, 1'b0);
      step(1);
      chk("t4_no_mem_en", men_cnt[0] - base, 0);
      push(0, 1'b1, 32'hCAFE_0011, 1'b0);
      push(0, 1'b0, 32'hCAFE_0010, 1'b0);
      set_req(0, 1'b0, 1'b0, 32'h40, 32'h0);
      set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
      wait_acks(0, ack_cnt[0] + 2, "t4_tie_acks");
      clr_req(0, 1'b0);
      clr_req(0, 1'b1);
      step(2);

      // 5: LAT3 build, ack five cycles after the sampling cycle
      push(2, 1'b0, 32'hCAFE_0004, 1'b0);
      set_req(2, 1'b0, 1'b0, 32'h10, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk($sformatf("t5_busy_c%0d", k), busy[2], 1);
         chk($sformatf("t5_no_ack_c%0d", k), m0_ack[2], 0);
      end
      step(1);
      chk("t5_ack", m0_ack[2], 1);
      chk("t5_rdata", m0_rdata[2], 32'hCAFE_0004);
      clr_req(2, 1'b0);
      step(1);
      chk("t5_idle", busy[2], 0);
      step(1);

      // 6: reset during WAIT aborts with no ack; a fresh request then completes
      push(2, 1'b0, 32'hCAFE_0005, 1'b0);
      set_req(2, 1'b0, 1'b0, 32'h14, 32'h0);
      step(2);
      chk("t6_busy_before", busy[2], 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_clear", {busy[2], mem_en[2], m0_ack[2], m1_ack[2]}, 0);
      void'(sbq[2].pop_back());
      clr_req(2, 1'b0);
      base = ack_cnt[2];
      step(2);
      rst = 1'b1;
      step(4);
      chk("t6_no_ack_after_rel", ack_cnt[2], base);
      txn(2, 1'b1, 1'b0, 32'h18, 32'h0, 32'hCAFE_0006, 1'b0, "t6_new_ok");
      step(2);
      chk("t6_sb_drained", sbq[2].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
